// File: rtl/rotate_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rotate_cmd_sequencer_if
// Description : Command handshake and rotation-control bus between a command
//               source and the rotate command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rotate_cmd_sequencer_if #(
  parameter int WIDTH = 100,
  parameter int AMT_W = 7
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] rot_data;
  logic [1:0]       rot_dir;
  logic             busy;
  logic             done;
  logic             err;

  // Command source side
  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data,
    input  cmd_ready, rot_data, rot_dir, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data,
    output cmd_ready, rot_data, rot_dir, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/rotate_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rotate_cmd_sequencer
// Description : Expands LOAD / ROTATE commands into a per-cycle control
//               stream (load word or single-bit steps) for the downstream
//               rotation register. Long rotations take the short way round.
// Revision    : 1.0 - initial release
// ============================================================================
module rotate_cmd_sequencer #(
  parameter int WIDTH = 100,
  parameter int AMT_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rotate_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_UP    = 2'd1;
  localparam logic [1:0] OP_DN    = 2'd2;

  localparam logic [1:0] DIR_LOAD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam logic [1:0] DIR_HOLD = 2'b11;

  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] HALF_A  = AMT_W'(WIDTH / 2);
  localparam logic [AMT_W-1:0] ONE_A   = AMT_W'(1);

  state_t           state_q,     state_d;
  logic [AMT_W-1:0] cnt_q,       cnt_d;
  logic [1:0]       rot_dir_q,   rot_dir_d;
  logic [WIDTH-1:0] rot_data_q,  rot_data_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             err_q,       err_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic             accept;
  logic             amt_bad;
  logic             long_way;
  logic [1:0]       req_code;
  logic [1:0]       eff_code;
  logic [AMT_W-1:0] eff_steps;

  // Decode the incoming command: acceptance and the effective (shortest) rotation
  always_comb begin
    accept    = bus.cmd_valid && cmd_ready_q;
    amt_bad   = (bus.cmd_amt >= WIDTH_A);
    long_way  = (bus.cmd_amt > HALF_A);
    req_code  = (bus.cmd_op == OP_UP) ? DIR_UP : DIR_DN;
    // Up and down codes are bitwise complements, so inverting flips direction
    eff_code  = long_way ? ~req_code : req_code;
    eff_steps = long_way ? (WIDTH_A - bus.cmd_amt) : bus.cmd_amt;
  end

  // Next-state and next-output logic; every output defaults to its idle value
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rot_dir_d  = DIR_HOLD;
    rot_data_d = rot_data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_LOAD: begin
              state_d    = S_LOAD;
              rot_dir_d  = DIR_LOAD;
              rot_data_d = bus.cmd_data;
              busy_d     = 1'b1;
            end
            OP_UP, OP_DN: begin
              if (amt_bad) begin
                err_d = 1'b1;
              end else if (eff_steps == '0) begin
                done_d = 1'b1;
              end else begin
                state_d   = S_STEP;
                cnt_d     = eff_steps;
                rot_dir_d = eff_code;
                busy_d    = 1'b1;
              end
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end

      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      S_STEP: begin
        // Counter holds the steps left including the one on the bus now
        if (cnt_q == ONE_A) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q - ONE_A;
          rot_dir_d = rot_dir_q;
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rot_dir_q   <= DIR_HOLD;
      rot_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rot_dir_q   <= rot_dir_d;
      rot_data_q  <= rot_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rot_dir   = rot_dir_q;
  assign bus.rot_data  = rot_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rotate_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotate_cmd_sequencer
// Description : Self-checking bench for rotate_cmd_sequencer: per-cycle
//               scoreboard of expected control words, a model of the
//               downstream rotation register, table-driven command vectors,
//               hand-written corner sequences and randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_cmd_sequencer;

  localparam int WIDTH = 100;
  localparam int AMT_W = 7;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DN   = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rotate_cmd_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  rotate_cmd_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One expected cycle of DUT outputs
  typedef struct {
    logic [1:0]       dir;
    logic             busy;
    logic             done;
    logic             err;
    logic             ready;
    logic [WIDTH-1:0] data;
  } exp_t;

  // One table vector: a command and what it must produce
  typedef struct {
    logic [1:0]       op;
    int               amt;
    logic [WIDTH-1:0] data;
    int               n_ld;
    int               n_up;
    int               n_dn;
    int               n_done;
    int               n_err;
    logic [WIDTH-1:0] exp_reg;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_data = '0;
  logic             rst_pend   = 1'b1;
  logic [WIDTH-1:0] down_reg;

  int ld_cnt, up_cnt, dn_cnt, done_cnt, err_cnt;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [1:0] dir, logic busy, logic done, logic err, logic ready, logic [WIDTH-1:0] data);
    exp_t r;
    r.dir = dir; r.busy = busy; r.done = done; r.err = err; r.ready = ready; r.data = data;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rotl(logic [WIDTH-1:0] x, int n);
    logic [WIDTH-1:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
    return r;
  endfunction

  // Expand an accepted command into the cycles it must produce, from c1 on
  task automatic plan(input logic [1:0] op, input int amt, input logic [WIDTH-1:0] d);
    int         k;
    logic [1:0] code;
    if (op == OP_LOAD) begin
      model_data = d;
      exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, d));
      exp_q.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b1, d));
    end else if (op == OP_NOP) begin
      exp_q.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b1, model_data));
    end else if (amt >= WIDTH) begin
      exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b1, model_data));
    end else begin
      if (amt <= WIDTH / 2) begin
        k    = amt;
        code = (op == OP_UP) ? 2'b01 : 2'b10;
      end else begin
        k    = WIDTH - amt;
        code = (op == OP_UP) ? 2'b10 : 2'b01;
      end
      for (int i = 0; i < k; i++) exp_q.push_back(mk(code, 1'b1, 1'b0, 1'b0, 1'b0, model_data));
      exp_q.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0, 1'b1, model_data));
    end
  endtask

  // Downstream rotation register driven by the DUT's control stream
  always @(posedge clk) begin
    case (bus.rot_dir)
      2'b00:   down_reg <= bus.rot_data;
      2'b01:   down_reg <= {down_reg[WIDTH-2:0], down_reg[WIDTH-1]};
      2'b10:   down_reg <= {down_reg[0], down_reg[WIDTH-1:1]};
      default: down_reg <= down_reg;
    endcase
  end

  // Per-cycle scoreboard: compare outputs, then note any command accepted at the next edge
  always @(negedge clk) begin : sb
    exp_t e;
    if (rst_pend) begin
      exp_q.delete();
      model_data = '0;
      e = mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, model_data);
    end
    chk("rot_dir",   WIDTH'(bus.rot_dir),   WIDTH'(e.dir));
    chk("busy",      WIDTH'(bus.busy),      WIDTH'(e.busy));
    chk("done",      WIDTH'(bus.done),      WIDTH'(e.done));
    chk("err",       WIDTH'(bus.err),       WIDTH'(e.err));
    chk("cmd_ready", WIDTH'(bus.cmd_ready), WIDTH'(e.ready));
    chk("rot_data",  bus.rot_data,          e.data);
    if (bus.rot_dir === 2'b00) ld_cnt++;
    if (bus.rot_dir === 2'b01) up_cnt++;
    if (bus.rot_dir === 2'b10) dn_cnt++;
    if (bus.done === 1'b1)     done_cnt++;
    if (bus.err === 1'b1)      err_cnt++;
    if (rst_n && bus.cmd_valid && e.ready) plan(bus.cmd_op, int'(bus.cmd_amt), bus.cmd_data);
    rst_pend = !rst_n;
  end

  task automatic clear_counts();
    ld_cnt = 0; up_cnt = 0; dn_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  // Present a command and hold it until the edge that accepts it
  task automatic send(input logic [1:0] op, input int amt, input logic [WIDTH-1:0] d);
    int guard;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = AMT_W'(amt);
    bus.cmd_data  = d;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1 || guard > 300) break;
      guard++;
    end
    if (guard > 300) chk("accept_timeout", WIDTH'(0), WIDTH'(1));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_amt   = AMT_W'($urandom);
    bus.cmd_data  = WIDTH'({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (exp_q.size() != 0 && guard < 300);
    if (guard >= 300) chk("idle_timeout", WIDTH'(0), WIDTH'(1));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  vec_t             vt[14];
  logic [WIDTH-1:0] d;

  initial begin
    vt[0]  = '{OP_LOAD, 0,   100'h1, 1, 0,  0,  1, 0, 100'h1};
    vt[1]  = '{OP_UP,   3,   '0,     0, 3,  0,  1, 0, 100'h8};
    vt[2]  = '{OP_LOAD, 0,   100'h1, 1, 0,  0,  1, 0, 100'h1};
    vt[3]  = '{OP_UP,   99,  '0,     0, 0,  1,  1, 0, 100'h8_0000_0000_0000_0000_0000_0000};
    vt[4]  = '{OP_DN,   50,  '0,     0, 0,  50, 1, 0, 100'h2_0000_0000_0000};
    vt[5]  = '{OP_DN,   51,  '0,     0, 49, 0,  1, 0, 100'h4_0000_0000_0000_0000_0000_0000};
    vt[6]  = '{OP_UP,   0,   '0,     0, 0,  0,  1, 0, 100'h4_0000_0000_0000_0000_0000_0000};
    vt[7]  = '{OP_UP,   100, '0,     0, 0,  0,  0, 1, 100'h4_0000_0000_0000_0000_0000_0000};
    vt[8]  = '{OP_UP,   127, '0,     0, 0,  0,  0, 1, 100'h4_0000_0000_0000_0000_0000_0000};
    vt[9]  = '{OP_NOP,  5,   '1,     0, 0,  0,  1, 0, 100'h4_0000_0000_0000_0000_0000_0000};
    vt[10] = '{OP_LOAD, 0,   100'h3, 1, 0,  0,  1, 0, 100'h3};
    vt[11] = '{OP_DN,   2,   '0,     0, 0,  2,  1, 0, 100'hC_0000_0000_0000_0000_0000_0000};
    vt[12] = '{OP_DN,   99,  '0,     0, 1,  0,  1, 0, 100'h8_0000_0000_0000_0000_0000_0001};
    vt[13] = '{OP_UP,   50,  '0,     0, 50, 0,  1, 0, 100'h6_0000_0000_0000};

    // Reset with a LOAD held valid: nothing may be accepted until release
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_amt   = '0;
    bus.cmd_data  = 100'hABC;
    clear_counts();
    cycles(3);
    rst_n = 1'b1;
    send(OP_LOAD, 0, 100'hABC);
    wait_idle();
    chk("reset_then_load_count", WIDTH'(ld_cnt), WIDTH'(1));
    chk("reset_then_load_reg",   down_reg, 100'hABC);

    // LOAD then ROT_UP 3 back-to-back
    clear_counts();
    send(OP_LOAD, 0, 100'h1);
    send(OP_UP, 3, '0);
    wait_idle();
    chk("b2b_up_steps", WIDTH'(up_cnt), WIDTH'(3));
    chk("b2b_reg",      down_reg, 100'h8);

    // Table-driven command vectors
    for (int i = 0; i < 14; i++) begin
      clear_counts();
      send(vt[i].op, vt[i].amt, vt[i].data);
      wait_idle();
      chk($sformatf("vec%0d_ld", i),   WIDTH'(ld_cnt),   WIDTH'(vt[i].n_ld));
      chk($sformatf("vec%0d_up", i),   WIDTH'(up_cnt),   WIDTH'(vt[i].n_up));
      chk($sformatf("vec%0d_dn", i),   WIDTH'(dn_cnt),   WIDTH'(vt[i].n_dn));
      chk($sformatf("vec%0d_done", i), WIDTH'(done_cnt), WIDTH'(vt[i].n_done));
      chk($sformatf("vec%0d_err", i),  WIDTH'(err_cnt),  WIDTH'(vt[i].n_err));
      chk($sformatf("vec%0d_reg", i),  down_reg,         vt[i].exp_reg);
    end

    // Reset after the 10th step of ROT_UP 40: steps discarded, no done
    d = WIDTH'({$urandom, $urandom, $urandom, $urandom});
    send(OP_LOAD, 0, d);
    wait_idle();
    clear_counts();
    send(OP_UP, 40, '0);
    cycles(9);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk("abort_reg", down_reg, rotl(d, 10));
    cycles(3);
    chk("abort_steps", WIDTH'(up_cnt),   WIDTH'(10));
    chk("abort_done",  WIDTH'(done_cnt), WIDTH'(0));
    chk("abort_err",   WIDTH'(err_cnt),  WIDTH'(0));

    // Randomized commands with random gaps and occasional resets
    for (int i = 0; i < 120; i++) begin
      send(2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 0) ? $urandom_range(0, WIDTH - 1) : $urandom_range(0, 127),
           WIDTH'({$urandom, $urandom, $urandom, $urandom}));
      if ($urandom_range(0, 14) == 0) begin
        cycles($urandom_range(0, 6));
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
      end
      cycles($urandom_range(0, 2));
    end
    wait_idle();
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
